// File: rtl/segdecode_pkg.sv
// Shared constants and types for the seven-segment frame decoder.
// Segment patterns are active-low, bit0=a .. bit6=g, and match the encoder.
package segdecode_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h27;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] DIG_NONE  = 4'hF;

  typedef enum logic {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } state_e;

  typedef struct packed {
    logic       ok;
    logic [1:0] idx;
  } sel_t;

  // Active-low one-hot digit select -> slot index; anything else is rejected.
  function automatic sel_t decode_sel(input logic [3:0] sel_n);
    sel_t r;
    r = '{ok: 1'b0, idx: 2'd0};
    case (sel_n)
      4'b1110: r = '{ok: 1'b1, idx: 2'd0};
      4'b1101: r = '{ok: 1'b1, idx: 2'd1};
      4'b1011: r = '{ok: 1'b1, idx: 2'd2};
      4'b0111: r = '{ok: 1'b1, idx: 2'd3};
      default: r = '{ok: 1'b0, idx: 2'd0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/segdecode_seg7_decode.sv
// Combinational seven-segment pattern to hex nibble decoder.
// Unknown patterns (including blank) give nibble 0 with valid_o low.
module seg7_decode
  import segdecode_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       valid_o
);

  always_comb begin
    nibble_o = 4'h0;
    valid_o  = 1'b1;
    case (seg_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: valid_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/segdecode.sv
// Receive-side seven-segment frame decoder: waits for each digit to hold
// steady, decodes it into its slot, and hands out 16-bit frames via valid/ready.
module segdecode
  import segdecode_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_sel,
  output logic [15:0] out_value,
  output logic        out_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overrun,
  input  logic        clr_overrun
);

  // Counter saturates one past the capture value so a long dwell captures once.
  localparam int             CW      = $clog2(STABLE_CYCLES + 2);
  localparam logic [CW-1:0]  CNT_CAP = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_SAT = CW'(STABLE_CYCLES + 1);

  logic [6:0]       seg_q;
  logic [3:0]       dig_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0][3:0]  slot_val_q, slot_val_d;
  logic [3:0]       slot_err_q, slot_err_d;
  logic [3:0]       seen_q, seen_d;
  state_e           state_q, state_d;
  logic [15:0]      out_value_q, out_value_d;
  logic             out_err_q, out_err_d;
  logic             overrun_q, overrun_d;

  logic [3:0]       dec_nib;
  logic             dec_ok;
  sel_t             sel;
  logic             stable;
  logic             capture;
  logic             complete;
  logic             load;
  logic             set_ovr;

  seg7_decode u_dec (
    .seg_i    (seg_q),
    .nibble_o (dec_nib),
    .valid_o  (dec_ok)
  );

  always_comb begin
    stable = (seg == seg_q) && (dig_sel == dig_q);
    if (!stable) begin
      cnt_d = CW'(1);
    end else if (cnt_q == CNT_SAT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    sel     = decode_sel(dig_q);
    capture = sel.ok && (cnt_q == CNT_CAP);
  end

  always_comb begin
    slot_val_d = slot_val_q;
    slot_err_d = slot_err_q;
    seen_d     = seen_q;
    complete   = 1'b0;
    if (capture) begin
      slot_val_d[sel.idx] = dec_nib;
      slot_err_d[sel.idx] = ~dec_ok;
      seen_d[sel.idx]     = 1'b1;
      complete            = (seen_d == 4'hF);
      if (complete) begin
        seen_d = 4'h0;
      end
    end
  end

  // Frame loads take the slot values including this cycle's capture.
  always_comb begin
    state_d     = state_q;
    out_value_d = out_value_q;
    out_err_d   = out_err_q;
    load        = 1'b0;
    set_ovr     = 1'b0;
    case (state_q)
      COLLECT: begin
        if (complete) begin
          load    = 1'b1;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (out_ready) begin
          if (complete) begin
            load = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end else if (complete) begin
          set_ovr = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
    if (load) begin
      out_value_d = slot_val_d;
      out_err_d   = |slot_err_d;
    end
    if (set_ovr) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q       <= SEG_BLANK;
      dig_q       <= DIG_NONE;
      cnt_q       <= '0;
      slot_val_q  <= '0;
      slot_err_q  <= '0;
      seen_q      <= '0;
      state_q     <= COLLECT;
      out_value_q <= '0;
      out_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      seg_q       <= seg;
      dig_q       <= dig_sel;
      cnt_q       <= cnt_d;
      slot_val_q  <= slot_val_d;
      slot_err_q  <= slot_err_d;
      seen_q      <= seen_d;
      state_q     <= state_d;
      out_value_q <= out_value_d;
      out_err_q   <= out_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_value = out_value_q;
  assign out_err   = out_err_q;
  assign out_valid = (state_q == PENDING);
  assign overrun   = overrun_q;

endmodule
